rns_mod_add_stage: RTL and testbench
====================================

# rns_mod_add_stage

Pipelined modulo-M adder front end for one 4-bit RNS channel. It accepts residue pairs over a valid/ready handshake and registers them. It then presents the raw sum, the modulus-corrected sum and a correction select to the 2:1 4-bit residue mux directly downstream, so that `result = sel ? cand_b : cand_a` is the canonical residue (x + y) mod M. An optional running-accumulate mode folds each result back in as the next operand.

## Interface
Parameters:
- `MODULUS`, default 13. Channel modulus; legal range 2..15.

Ports:
- `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
- `rst_n`: input, 1 bit. Synchronous, active-low reset.
- `in_valid`: input, 1 bit. Operand pair present.
- `in_ready`: output, 1 bit. Block can accept this cycle.
- `x`: input, 4 bits. First residue.
- `y`: input, 4 bits. Second residue; ignored in accumulate mode.
- `acc_mode`: input, 1 bit. Per-transaction; 1 means use the accumulator instead of `y`.
- `acc_clr`: input, 1 bit. Zeroes the accumulator.
- `out_valid`: output, 1 bit. Candidates valid.
- `out_ready`: input, 1 bit. Downstream accepts.
- `cand_a`: output, 4 bits. Uncorrected sum, low 4 bits.
- `cand_b`: output, 4 bits. Sum minus `MODULUS`, low 4 bits.
- `sel`: output, 1 bit. 1 when sum ≥ `MODULUS`; drives the mux select.
- `err`: output, 1 bit. Sticky out-of-range operand flag.

## Operation
- Two register stages:
  - S1 captures `x`, `y`, `acc_mode` and a valid bit.
  - S2 computes the sum and candidates and drives the outputs.
- Arithmetic in S2, 5-bit unsigned:
  - `sum = x + opnd`, where `opnd` = `y`, or the accumulator when `acc_mode` = 1.
  - `diff = sum − MODULUS`, mod 32.
  - `cand_a = sum[3:0]`, `cand_b = diff[3:0]`, `sel = (sum ≥ MODULUS)`.
- For canonical inputs (< `MODULUS`), the selected candidate is always < `MODULUS` and fits in 4 bits.
- Accumulator: 4-bit register, reset to 0.
  - Effective value = 0 if `acc_clr` is high this cycle, else the stored value.
  - On an S2 load with `acc_mode` = 1: the operand is the effective value, and the accumulator takes `sel ? cand_b : cand_a`.
  - On an S2 load with `acc_mode` = 0: the accumulator is untouched, except that `acc_clr` still zeroes it.
- `err` sets when an accepted `x` ≥ `MODULUS`, or when an accepted `y` ≥ `MODULUS` with `acc_mode` = 0. It clears only on reset. Out-of-range transactions still flow through, computed per the formulas above.
- Handshake:
  - `s2_load = s1_valid & (~out_valid | out_ready)`.
  - `s1_load = in_valid & in_ready`.
  - `in_ready = ~s1_valid | s2_load`, combinational from state and `out_ready`.
  - Order is preserved; no drop or duplication.
- Output stability: while `out_valid` is high and `out_ready` is low, `cand_a`, `cand_b` and `sel` hold.

## Timing
- Reset (`rst_n` = 0 at an edge) clears:
  - `in_ready` = 1 (after reset), `out_valid` = 0, `cand_a` = 0, `cand_b` = 0, `sel` = 0, `err` = 0;
  - the accumulator and S1 contents.
- Reset mid-operation discards both in-flight items. There is no partial output.
- Latency: a pair accepted at edge k appears with `out_valid` = 1 after edge k+1, i.e. 2 cycles.
- Throughput: 1 pair per cycle while `out_ready` = 1.
- Full condition: S1 and S2 both occupied and `out_ready` = 0 forces `in_ready` = 0. At most 2 items are buffered.
- Simultaneous output pop and input push in a full pipeline: both occur in the same cycle and `in_ready` stays high.
- Back-to-back accumulate: the result of item n is visible as the operand of item n+1 with no bubble, because the accumulator updates on the same edge that S2 loads.

## Configuration
- `RNS_MOD_ADD_ACC_EN` defined: the accumulator, `acc_mode` and `acc_clr` behave as specified.
- Not defined:
  - no accumulator register is built;
  - `acc_mode` and `acc_clr` remain as ports but are ignored, and `opnd` is always `y`;
  - the `err` check always includes `y`.

## Test plan
- M=13, x=5, y=6 → 2 cycles later `cand_a`=11, `cand_b`=14, `sel`=0; mux result 11.
- M=13, x=9, y=7 → `cand_a`=0, `cand_b`=3, `sel`=1 (16 mod 13 = 3). Boundary case x=12, y=1 → `cand_a`=13, `cand_b`=0, `sel`=1.
- Stream 4 pairs with `out_ready`=0 for 3 cycles → `in_ready` drops after 2 acceptances, outputs hold steady, then all 4 results emerge in order with none lost.
- With `RNS_MOD_ADD_ACC_EN`, M=13, `acc_mode`=1, x=7 three times → results 7, 1, 8. Then `acc_clr` together with x=4 → result 4.
- Accept x=14 (M=13) → `err` goes to 1 and stays 1 through later legal traffic until `rst_n` = 0.
- Assert `rst_n`=0 with 2 items in flight → next cycle `out_valid`=0, `in_ready`=1, all outputs 0, accumulator 0.

Source files
------------

// File: rtl/rns_mod_add_stage.sv
// rns_mod_add_stage: two-stage modulo-MODULUS adder front end for one 4-bit RNS channel.
// S1 registers the operand pair; S2 registers the raw sum, the modulus-corrected sum
// and the mux select, so the downstream 2:1 mux yields (x + opnd) mod MODULUS.
// Optional feature macro: RNS_MOD_ADD_ACC_EN builds the running accumulator.
module rns_mod_add_stage #(
   parameter int MODULUS = 13
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       acc_mode,
   input  logic       acc_clr,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] cand_a,
   output logic [3:0] cand_b,
   output logic       sel,
   output logic       err
);

   localparam logic [4:0] MOD5 = 5'(MODULUS);

   // Stage registers
   logic       s1_valid_q, s1_valid_d;
   logic [3:0] s1_x_q, s1_x_d;
   logic [3:0] s1_y_q, s1_y_d;
   logic       out_valid_q, out_valid_d;
   logic [3:0] cand_a_q, cand_a_d;
   logic [3:0] cand_b_q, cand_b_d;
   logic       sel_q, sel_d;
   logic       err_q, err_d;

   // Combinational datapath and handshake
   logic       s1_load;
   logic       s2_load;
   logic       mode_eff;
   logic [3:0] opnd;
   logic [4:0] sum;
   logic [4:0] diff;
   logic       sum_ge;
   logic       x_bad;
   logic       y_bad;

`ifdef RNS_MOD_ADD_ACC_EN
   logic       s1_acc_q, s1_acc_d;
   logic [3:0] acc_q, acc_d;
   logic [3:0] acc_eff;

   // Accumulate-mode operand selection: acc_clr forces a zero operand this cycle
   always_comb begin
      acc_eff  = acc_clr ? 4'd0 : acc_q;
      opnd     = s1_acc_q ? acc_eff : s1_y_q;
      mode_eff = acc_mode;
   end
`else
   logic unused_acc_ports;
   assign unused_acc_ports = &{1'b0, acc_mode, acc_clr};

   // Without the accumulator the second operand is always y and y is always range-checked
   always_comb begin
      opnd     = s1_y_q;
      mode_eff = 1'b0;
   end
`endif

   // Handshake: S2 refills when empty or draining; S1 accepts when empty or moving on
   always_comb begin
      s2_load  = s1_valid_q & (~out_valid_q | out_ready);
      in_ready = ~s1_valid_q | s2_load;
      s1_load  = in_valid & in_ready;
   end

   // S2 arithmetic: 5-bit raw sum, wrapped difference and correction select
   always_comb begin
      sum    = {1'b0, s1_x_q} + {1'b0, opnd};
      diff   = sum - MOD5;
      sum_ge = (sum >= MOD5);
      x_bad  = ({1'b0, x} >= MOD5);
      y_bad  = ({1'b0, y} >= MOD5) & ~mode_eff;
   end

   // Next-state for S1, S2 and the sticky error flag
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_x_d      = s1_x_q;
      s1_y_d      = s1_y_q;
      out_valid_d = out_valid_q;
      cand_a_d    = cand_a_q;
      cand_b_d    = cand_b_q;
      sel_d       = sel_q;
      err_d       = err_q;

      if (s1_load) begin
         s1_valid_d = 1'b1;
         s1_x_d     = x;
         s1_y_d     = y;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end else begin
         s1_valid_d = s1_valid_q;
      end

      if (s2_load) begin
         out_valid_d = 1'b1;
         cand_a_d    = sum[3:0];
         cand_b_d    = diff[3:0];
         sel_d       = sum_ge;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end

      if (s1_load && (x_bad || y_bad)) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

`ifdef RNS_MOD_ADD_ACC_EN
   // Accumulator and captured mode: result folds back on the same edge S2 loads
   always_comb begin
      s1_acc_d = s1_acc_q;
      acc_d    = acc_q;
      if (s1_load) begin
         s1_acc_d = acc_mode;
      end else begin
         s1_acc_d = s1_acc_q;
      end
      if (s2_load && s1_acc_q) begin
         acc_d = sum_ge ? diff[3:0] : sum[3:0];
      end else if (acc_clr) begin
         acc_d = 4'd0;
      end else begin
         acc_d = acc_q;
      end
   end

   // Accumulator state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_acc_q <= 1'b0;
         acc_q    <= 4'd0;
      end else begin
         s1_acc_q <= s1_acc_d;
         acc_q    <= acc_d;
      end
   end
`endif

   // Pipeline and flag registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_x_q      <= 4'd0;
         s1_y_q      <= 4'd0;
         out_valid_q <= 1'b0;
         cand_a_q    <= 4'd0;
         cand_b_q    <= 4'd0;
         sel_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_x_q      <= s1_x_d;
         s1_y_q      <= s1_y_d;
         out_valid_q <= out_valid_d;
         cand_a_q    <= cand_a_d;
         cand_b_q    <= cand_b_d;
         sel_q       <= sel_d;
         err_q       <= err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign cand_a    = cand_a_q;
   assign cand_b    = cand_b_q;
   assign sel       = sel_q;
   assign err       = err_q;

endmodule

// File: tb/tb_rns_mod_add_stage.sv
// Testbench for rns_mod_add_stage: directed cases plus randomized traffic checked
// against a transaction-level modulo-add model and an in-order scoreboard.
module tb_rns_mod_add_stage;

   localparam int M = 13;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] x;
   logic [3:0] y;
   logic       acc_mode;
   logic       acc_clr;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] cand_a;
   logic [3:0] cand_b;
   logic       sel;
   logic       err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       s;
      logic [3:0] r;
      bit         canon;
   } exp_t;

   exp_t       sb[$];
   int         acc_model = 0;
   logic       err_exp = 1'b0;
   bit         fire_in;
   bit         hold_pending = 1'b0;
   logic [8:0] held;
   logic [3:0] pairs_x[4] = '{4'd1, 4'd12, 4'd9, 4'd0};
   logic [3:0] pairs_y[4] = '{4'd2, 4'd12, 4'd3, 4'd0};

   rns_mod_add_stage #(.MODULUS(M)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .acc_mode(acc_mode), .acc_clr(acc_clr),
      .out_valid(out_valid), .out_ready(out_ready),
      .cand_a(cand_a), .cand_b(cand_b), .sel(sel), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // One clock cycle: check at the falling edge, drive, then let the rising edge happen.
   task automatic step(input bit iv, input logic [3:0] xv, input logic [3:0] yv,
                       input bit am, input bit ac, input bit ordy);
      exp_t e;
      int   opnd;
      int   sum;
      @(negedge clk);
      chk("err_sticky", {8'd0, err}, {8'd0, err_exp});
      if (hold_pending && out_valid)
         chk("hold_stable", {out_valid, cand_a, cand_b}, held);
      in_valid  = iv;
      x         = xv;
      y         = yv;
      acc_mode  = am;
      acc_clr   = ac;
      out_ready = ordy;
      #1;
      chk("in_ready", {8'd0, in_ready}, {8'd0, (sb.size() < 2) || ordy});
      fire_in = in_valid && in_ready;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", 9'd1, 9'd0);
         end else begin
            e = sb.pop_front();
            chk("cand_a", {5'd0, cand_a}, {5'd0, e.a});
            chk("cand_b", {5'd0, cand_b}, {5'd0, e.b});
            chk("sel", {8'd0, sel}, {8'd0, e.s});
            if (e.canon)
               chk("mux_result", {5'd0, (sel ? cand_b : cand_a)}, {5'd0, e.r});
         end
      end
      hold_pending = out_valid && !out_ready;
      held = {out_valid, cand_a, cand_b};
      if (fire_in) begin
`ifdef RNS_MOD_ADD_ACC_EN
         if (am && ac) acc_model = 0;
         opnd = am ? acc_model : int'(yv);
         if ((int'(xv) >= M) || (!am && int'(yv) >= M)) err_exp = 1'b1;
`else
         opnd = int'(yv);
         if ((int'(xv) >= M) || (int'(yv) >= M)) err_exp = 1'b1;
`endif
         sum     = int'(xv) + opnd;
         e.a     = 4'(sum % 16);
         e.b     = 4'(((sum - M + 32) % 32) % 16);
         e.s     = (sum >= M);
         e.r     = 4'(sum % M);
         e.canon = (int'(xv) < M) && (opnd < M);
`ifdef RNS_MOD_ADD_ACC_EN
         if (am) acc_model = sum % M;
`endif
         sb.push_back(e);
      end
      @(posedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
         n++;
      end
      chk("drain_empty", 9'(sb.size()), 9'd0);
   endtask

   task automatic reset_model();
      sb.delete();
      acc_model    = 0;
      err_exp      = 1'b0;
      hold_pending = 1'b0;
   endtask

   initial begin
      int idx;
      rst_n = 1'b0; in_valid = 1'b0; x = 4'd0; y = 4'd0;
      acc_mode = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {8'd0, out_valid}, 9'd0);
      chk("rst_in_ready", {8'd0, in_ready}, 9'd1);
      chk("rst_cands", {1'b0, cand_a, cand_b}, 9'd0);
      chk("rst_sel_err", {7'd0, sel, err}, 9'd0);
      rst_n = 1'b1;

      // 5 + 6 with latency check
      step(1'b1, 4'd5, 4'd6, 1'b0, 1'b0, 1'b1);
      #1 chk("latency_not_yet", {8'd0, out_valid}, 9'd0);
      step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
      #1 chk("latency_two", {8'd0, out_valid}, 9'd1);
      drain();

      // 9 + 7 and boundary 12 + 1, back to back
      step(1'b1, 4'd9, 4'd7, 1'b0, 1'b0, 1'b1);
      step(1'b1, 4'd12, 4'd1, 1'b0, 1'b0, 1'b1);
      drain();

      // Four pairs with out_ready low for the first three cycles
      idx = 0;
      for (int c = 0; c < 30 && (idx < 4 || sb.size() != 0); c++) begin
         if (idx < 4)
            step(1'b1, pairs_x[idx], pairs_y[idx], 1'b0, 1'b0, c >= 3);
         else
            step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
         if (fire_in) idx++;
      end
      chk("stall_all_sent", 9'(idx), 9'd4);
      chk("stall_all_out", 9'(sb.size()), 9'd0);

`ifdef RNS_MOD_ADD_ACC_EN
      // Running accumulate: 7, 1, 8, then clear with 4
      repeat (3) step(1'b1, 4'd7, 4'd0, 1'b1, 1'b0, 1'b1);
      drain();
      step(1'b1, 4'd4, 4'd0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1);
      drain();
`endif

      // Out-of-range x sets the sticky flag; legal traffic afterwards
      step(1'b1, 4'd14, 4'd2, 1'b0, 1'b0, 1'b1);
      step(1'b1, 4'd3, 4'd4, 1'b0, 1'b0, 1'b1);
      drain();
      chk("err_set", {8'd0, err}, 9'd1);

      // Randomized canonical traffic with random backpressure
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 3) != 0, 4'($urandom_range(0, M - 1)),
              4'($urandom_range(0, M - 1)), 1'b0, 1'b0, $urandom_range(0, 2) != 0);
      end
      drain();

      // Reset with two items in flight
      step(1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_out_valid", {8'd0, out_valid}, 9'd0);
      chk("midrst_in_ready", {8'd0, in_ready}, 9'd1);
      chk("midrst_cands", {1'b0, cand_a, cand_b}, 9'd0);
      chk("midrst_sel_err", {7'd0, sel, err}, 9'd0);
      reset_model();
      @(negedge clk);
      rst_n = 1'b1;

      // Post-reset item: in accumulate mode this exposes a cleared accumulator
      step(1'b1, 4'd3, 4'd5, 1'b1, 1'b0, 1'b1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
